aoc_day3_line_framer: RTL and testbench

//   Upstream stage of aoc_day3: converts the raw ASCII puzzle byte stream into the

---
 rtl/aoc_day3_pkg.sv | 35 +++
 rtl/aoc_day3_gap_timer.sv | 34 +++
 rtl/aoc_day3_line_framer.sv | 151 +++++++++++++++
 tb/tb_aoc_day3_line_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_day3_pkg.sv
// Shared constants and types for the aoc_day3 input framer.
// Holds ASCII codes, error codes, framer states and parameter helpers.
package aoc_day3_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_CHAR = 2'd1,
    ERR_SHORT    = 2'd2,
    ERR_LONG     = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ACCEPT,
    GAP,
    LGAP,
    HALT
  } framer_state_t;

  // The timer is loaded with gap-1 so that it reaches zero on the last gap cycle.
  function automatic int gap_load(input int g);
    return (g > 0) ? g - 1 : 0;
  endfunction

  function automatic int gap_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aoc_day3_gap_timer.sv
// Loadable down-counter; busy while the count is non-zero.
// A load takes effect on the next clock and overrides any count in progress.
module aoc_day3_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/aoc_day3_line_framer.sv
// Turns the raw ASCII puzzle stream into paced digit strobes and line-done pulses.
// Digits and line_done appear one cycle after the accepting handshake; errors halt until reset.
module aoc_day3_line_framer
  import aoc_day3_pkg::*;
#(
  parameter int DIGITS_PER_NUM = 15,
  parameter int DIGIT_GAP      = 3,
  parameter int LINE_GAP       = 8,
  parameter int LINE_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [3:0]            digit_out,
  output logic                  digit_valid,
  output logic                  line_done,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int COL_W = $clog2(DIGITS_PER_NUM + 1);
  localparam int GAP_W = gap_width(DIGIT_GAP, LINE_GAP);
  localparam logic [COL_W-1:0]      COL_MAX = COL_W'(DIGITS_PER_NUM);
  localparam logic [GAP_W-1:0]      DGAP_LD = GAP_W'(gap_load(DIGIT_GAP));
  localparam logic [GAP_W-1:0]      LGAP_LD = GAP_W'(gap_load(LINE_GAP));
  localparam logic [LINE_CNT_W-1:0] CNT_MAX = '1;

  framer_state_t         state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [3:0]            digit_q, digit_d;
  logic                  dv_q, dv_d;
  logic                  ld_q, ld_d;
  logic [LINE_CNT_W-1:0] cnt_q, cnt_d;
  err_code_t             err_q, err_d;
  logic                  error_q, error_d;
  logic                  tmr_load;
  logic [GAP_W-1:0]      tmr_val;
  logic                  tmr_busy;
  logic                  is_digit;

  assign is_digit = (byte_in >= ASCII_0) && (byte_in <= ASCII_9);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    digit_d  = digit_q;
    dv_d     = 1'b0;
    ld_d     = 1'b0;
    cnt_d    = cnt_q;
    err_d    = err_q;
    error_d  = error_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ACCEPT: begin
        if (byte_valid) begin
          if (is_digit) begin
            if (col_q < COL_MAX) begin
              // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
              digit_d = byte_in[3:0];
              dv_d    = 1'b1;
              col_d   = col_q + 1'b1;
              if (DIGIT_GAP != 0) begin
                state_d  = GAP;
                tmr_load = 1'b1;
                tmr_val  = DGAP_LD;
              end
            end else begin
              err_d   = ERR_LONG;
              error_d = 1'b1;
              state_d = HALT;
            end
          end else if (byte_in == ASCII_CR) begin
            state_d = ACCEPT;
          end else if (byte_in == ASCII_LF) begin
            if (col_q == COL_MAX) begin
              ld_d  = 1'b1;
              col_d = '0;
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
              if (LINE_GAP != 0) begin
                state_d  = LGAP;
                tmr_load = 1'b1;
                tmr_val  = LGAP_LD;
              end
            end else if (col_q != '0) begin
              err_d   = ERR_SHORT;
              error_d = 1'b1;
              state_d = HALT;
            end
          end else begin
            err_d   = ERR_BAD_CHAR;
            error_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      GAP, LGAP: begin
        if (!tmr_busy) state_d = ACCEPT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      col_q   <= '0;
      digit_q <= '0;
      dv_q    <= 1'b0;
      ld_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      error_q <= error_d;
    end
  end

  aoc_day3_gap_timer #(
    .W(GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .busy     (tmr_busy)
  );

  // HALT keeps accepting so the upstream source can drain.
  assign byte_ready  = (state_q == ACCEPT) || (state_q == HALT);
  assign digit_out   = digit_q;
  assign digit_valid = dv_q;
  assign line_done   = ld_q;
  assign line_count  = cnt_q;
  assign error       = error_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_aoc_day3_line_framer.sv
// Directed bench for the line framer: two instances (3 and 2 digits per line).
module tb_aoc_day3_line_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  b3_in, b2_in;
  logic        b3_vld, b2_vld;
  logic        rdy3, rdy2;
  logic [3:0]  d3, d2;
  logic        dv3, dv2, ld3, ld2, er3, er2;
  logic [15:0] lc3, lc2;
  logic [1:0]  ec3, ec2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ldn3  = 0;
  int ldn2  = 0;
  int ldc3  = 0;
  int both  = 0;
  int dq3[$];
  int dc3[$];
  int dq2[$];

  aoc_day3_line_framer #(.DIGITS_PER_NUM(3), .DIGIT_GAP(3), .LINE_GAP(8), .LINE_CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .byte_in(b3_in), .byte_valid(b3_vld), .byte_ready(rdy3),
    .digit_out(d3), .digit_valid(dv3), .line_done(ld3), .line_count(lc3),
    .error(er3), .err_code(ec3)
  );

  aoc_day3_line_framer #(.DIGITS_PER_NUM(2), .DIGIT_GAP(3), .LINE_GAP(8), .LINE_CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .byte_in(b2_in), .byte_valid(b2_vld), .byte_ready(rdy2),
    .digit_out(d2), .digit_valid(dv2), .line_done(ld2), .line_count(lc2),
    .error(er2), .err_code(ec2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records output strobes shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      if (dv3) begin dq3.push_back(int'(d3)); dc3.push_back(cyc); end
      if (ld3) begin ldn3++; ldc3 = cyc; end
      if (dv3 && ld3) both++;
      if (dv2) dq2.push_back(int'(d2));
      if (ld2) ldn2++;
      if (dv2 && ld2) both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a byte and returns at the falling edge before the accepting rising edge.
  task automatic send(input bit sel, input logic [7:0] b, output int hs);
    int g;
    g = 0;
    @(negedge clk);
    if (sel) begin b2_in = b; b2_vld = 1'b1; end
    else     begin b3_in = b; b3_vld = 1'b1; end
    while (!(sel ? rdy2 : rdy3) && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("byte_ready_wait", 32'(sel ? rdy2 : rdy3), 32'd1);
    hs = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    b3_vld = 1'b0;
    b2_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    b3_vld = 1'b0;
    b2_vld = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hs, hs_lf, low, base, ldb;
    rst_n = 1'b1; b3_in = 8'h00; b2_in = 8'h00; b3_vld = 1'b0; b2_vld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready",  32'(rdy3), 32'd1);
    chk("rst_dvalid", 32'(dv3),  32'd0);
    chk("rst_ldone",  32'(ld3),  32'd0);
    chk("rst_lcount", 32'(lc3),  32'd0);
    chk("rst_error",  32'(er3),  32'd0);
    chk("rst_ecode",  32'(ec3),  32'd0);
    chk("rst_digit",  32'(d3),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // "12\r\n" with two digits per line
    send(1'b1, 8'h31, hs); send(1'b1, 8'h32, hs); send(1'b1, 8'h0D, hs); send(1'b1, 8'h0A, hs);
    idle();
    chk("t2_ndig",  32'(dq2.size()), 32'd2);
    chk("t2_dig0",  32'(dq2[0]), 32'd1);
    chk("t2_dig1",  32'(dq2[1]), 32'd2);
    chk("t2_ldn",   32'(ldn2), 32'd1);
    chk("t2_lcnt",  32'(lc2),  32'd1);
    chk("t2_err",   32'(er2),  32'd0);
    chk("t2_ecode", 32'(ec2),  32'd0);

    // "987\n" held valid: 4-cycle digit pacing, 8-cycle line gap
    send(1'b0, 8'h39, hs); send(1'b0, 8'h38, hs); send(1'b0, 8'h37, hs); send(1'b0, 8'h0A, hs_lf);
    low = 0;
    @(negedge clk);
    b3_vld = 1'b0;
    while (!rdy3 && low < 40) begin low++; @(negedge clk); end
    chk("t1_ndig",   32'(dq3.size()), 32'd3);
    chk("t1_dig0",   32'(dq3[0]), 32'd9);
    chk("t1_dig1",   32'(dq3[1]), 32'd8);
    chk("t1_dig2",   32'(dq3[2]), 32'd7);
    chk("t1_space0", 32'(dc3[1] - dc3[0]), 32'd4);
    chk("t1_space1", 32'(dc3[2] - dc3[1]), 32'd4);
    chk("t1_ldcyc",  32'(ldc3), 32'(hs_lf + 1));
    chk("t1_ldn",    32'(ldn3), 32'd1);
    chk("t1_lcnt",   32'(lc3),  32'd1);
    chk("t1_lgap",   32'(low),  32'd8);
    chk("t1_err",    32'(er3),  32'd0);

    // "1234\n": too long, halt and drain
    base = dq3.size();
    send(1'b0, 8'h31, hs); send(1'b0, 8'h32, hs); send(1'b0, 8'h33, hs);
    send(1'b0, 8'h34, hs); send(1'b0, 8'h0A, hs);
    idle();
    chk("t3_ndig",  32'(dq3.size() - base), 32'd3);
    chk("t3_dig2",  32'(dq3[base+2]), 32'd3);
    chk("t3_err",   32'(er3), 32'd1);
    chk("t3_ecode", 32'(ec3), 32'd3);
    chk("t3_ldn",   32'(ldn3), 32'd1);
    chk("t3_lcnt",  32'(lc3),  32'd1);
    send(1'b0, 8'h78, hs);
    idle();
    chk("t3_sticky", 32'(ec3), 32'd3);
    chk("t3_ready",  32'(rdy3), 32'd1);

    // "12\n": too short; later bad char must not overwrite
    do_reset();
    ldb = ldn3;
    send(1'b0, 8'h31, hs); send(1'b0, 8'h32, hs); send(1'b0, 8'h0A, hs);
    idle();
    chk("t4_ecode_short", 32'(ec3), 32'd2);
    chk("t4_err",         32'(er3), 32'd1);
    chk("t4_ldn",         32'(ldn3 - ldb), 32'd0);
    send(1'b0, 8'h61, hs);
    idle();
    chk("t4_sticky_short", 32'(ec3), 32'd2);

    // "1a": bad char, then more bytes discarded
    do_reset();
    send(1'b0, 8'h31, hs); send(1'b0, 8'h61, hs);
    idle();
    chk("t4_ecode_bad", 32'(ec3), 32'd1);
    chk("t4_err_bad",   32'(er3), 32'd1);
    base = dq3.size();
    send(1'b0, 8'h0A, hs); send(1'b0, 8'h39, hs);
    idle();
    chk("t4_sticky_bad", 32'(ec3), 32'd1);
    chk("t4_no_digit",   32'(dq3.size() - base), 32'd0);

    // "\n\n555\n": blank lines ignored
    do_reset();
    ldb  = ldn3;
    base = dq3.size();
    send(1'b0, 8'h0A, hs); send(1'b0, 8'h0A, hs);
    send(1'b0, 8'h35, hs); send(1'b0, 8'h35, hs); send(1'b0, 8'h35, hs); send(1'b0, 8'h0A, hs);
    idle();
    chk("t5_lcnt", 32'(lc3), 32'd1);
    chk("t5_err",  32'(er3), 32'd0);
    chk("t5_ldn",  32'(ldn3 - ldb), 32'd1);
    chk("t5_ndig", 32'(dq3.size() - base), 32'd3);
    chk("t5_dig",  32'(dq3[base+1]), 32'd5);

    // reset mid-line after two digits, then a fresh line
    do_reset();
    send(1'b0, 8'h33, hs); send(1'b0, 8'h32, hs);
    idle();
    chk("t6_pre_digit", 32'(d3),  32'd2);
    chk("t6_pre_dv",    32'(dv3), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_digit", 32'(d3),   32'd0);
    chk("t6_rst_dv",    32'(dv3),  32'd0);
    chk("t6_rst_ready", 32'(rdy3), 32'd1);
    chk("t6_rst_lcnt",  32'(lc3),  32'd0);
    chk("t6_rst_err",   32'(er3),  32'd0);
    chk("t6_rst_ecode", 32'(ec3),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = dq3.size();
    send(1'b0, 8'h33, hs); send(1'b0, 8'h32, hs); send(1'b0, 8'h31, hs); send(1'b0, 8'h0A, hs);
    idle();
    chk("t6_lcnt", 32'(lc3), 32'd1);
    chk("t6_err",  32'(er3), 32'd0);
    chk("t6_ndig", 32'(dq3.size() - base), 32'd3);
    chk("t6_dig2", 32'(dq3[base+2]), 32'd1);

    chk("no_overlap", 32'(both), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
